// File: rtl/bpb_pkg.sv
// Shared types and defaults for the BPB update scheduler: default sizes,
// the queued update record, the scheduler state and a saturating counter helper.
package bpb_pkg;

  localparam int ENTRIES_DEF   = 64;
  localparam int TAG_WIDTH_DEF = 10;
  localparam int DEPTH_DEF     = 4;
  localparam int IDX_W_DEF     = $clog2(ENTRIES_DEF);

  typedef struct packed {
    logic [IDX_W_DEF-1:0]     idx;
    logic [TAG_WIDTH_DEF-1:0] tag;
    logic                     taken;
    logic                     mistake;
  } bpb_upd_t;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } sched_state_e;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'd0, b};
    sat_add8 = sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/bpb_upd_fifo.sv
// Two-write / one-read circular update queue. Slot order is push0 then push1;
// a flush empties the queue and overrides same-cycle pushes and pops.
module bpb_upd_fifo
  import bpb_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEF,
  parameter type T     = bpb_upd_t,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push0,
  input  T              din0,
  input  logic          push1,
  input  T              din1,
  input  logic          pop,
  output T              head,
  output logic [CW-1:0] count
);

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] n_push;
  T              slot0;

  // Next pointers, count and storage; a lone push1 lands in the first free slot.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    slot0    = push0 ? din0 : din1;
    n_push   = CW'(push0) + CW'(push1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push0 || push1) begin
        mem_d[wr_ptr_q] = slot0;
      end else begin
        mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
      end
      if (push0 && push1) begin
        mem_d[wr_ptr_q + PW'(1)] = din1;
      end else begin
        mem_d[wr_ptr_q + PW'(1)] = mem_q[wr_ptr_q + PW'(1)];
      end
      wr_ptr_d = wr_ptr_q + PW'(n_push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + n_push - CW'(pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/bpb_update_sched.sv
// BPB write scheduler: queues retire-pipe updates in program order, drains one
// per cycle onto the BPB write port, runs full-table clear sweeps, owns mod_cfg.
module bpb_update_sched
  import bpb_pkg::*;
#(
  parameter int  ENTRIES   = ENTRIES_DEF,
  parameter int  TAG_WIDTH = TAG_WIDTH_DEF,
  parameter int  DEPTH     = DEPTH_DEF,
  localparam int IDX_W     = $clog2(ENTRIES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 u0_valid,
  input  logic [IDX_W-1:0]     u0_idx,
  input  logic [TAG_WIDTH-1:0] u0_tag,
  input  logic                 u0_taken,
  input  logic                 u0_mistake,
  input  logic                 u1_valid,
  input  logic [IDX_W-1:0]     u1_idx,
  input  logic [TAG_WIDTH-1:0] u1_tag,
  input  logic                 u1_taken,
  input  logic                 u1_mistake,
  output logic                 upd_ready,
  input  logic                 clear_req,
  input  logic                 mod_set,
  input  logic                 mod_val,
  output logic                 mod_cfg,
  output logic                 bpb_wen,
  output logic [IDX_W-1:0]     bpb_idx,
  output logic [TAG_WIDTH-1:0] bpb_tag,
  output logic                 bpb_taken,
  output logic                 bpb_mistake,
  output logic                 bpb_clear,
  output logic                 busy,
  output logic [7:0]           drop_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [IDX_W-1:0]     idx;
    logic [TAG_WIDTH-1:0] tag;
    logic                 taken;
    logic                 mistake;
  } upd_t;

  sched_state_e   state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic           mod_cfg_q, mod_cfg_d;
  logic [7:0]     drop_cnt_q, drop_cnt_d;

  upd_t           din0_s, din1_s, head_s;
  logic [CW-1:0]  count_s;
  logic           push0_s, push1_s, pop_s;
  logic [1:0]     n_drop_s;

  assign din0_s    = '{idx: u0_idx, tag: u0_tag, taken: u0_taken, mistake: u0_mistake};
  assign din1_s    = '{idx: u1_idx, tag: u1_tag, taken: u1_taken, mistake: u1_mistake};
  assign upd_ready = (state_q == ST_RUN) && (count_s <= CW'(DEPTH - 2));
  assign push0_s   = u0_valid && upd_ready;
  assign push1_s   = u1_valid && upd_ready;
  assign pop_s     = (state_q == ST_RUN) && bpb_wen;

  bpb_upd_fifo #(
    .DEPTH (DEPTH),
    .T     (upd_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (clear_req),
    .push0 (push0_s),
    .din0  (din0_s),
    .push1 (push1_s),
    .din1  (din1_s),
    .pop   (pop_s),
    .head  (head_s),
    .count (count_s)
  );

  // Write port: queue head in RUN, sweep pointer in CLEAR; held off during reset.
  always_comb begin
    bpb_wen     = 1'b0;
    bpb_clear   = 1'b0;
    bpb_idx     = '0;
    bpb_tag     = '0;
    bpb_taken   = 1'b0;
    bpb_mistake = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (count_s != '0) begin
          bpb_wen     = !stall && reset;
          bpb_idx     = head_s.idx;
          bpb_tag     = head_s.tag;
          bpb_taken   = head_s.taken;
          bpb_mistake = head_s.mistake;
        end else begin
          bpb_wen     = 1'b0;
        end
      end
      ST_CLEAR: begin
        bpb_wen   = !stall && reset;
        bpb_clear = !stall && reset;
        bpb_idx   = ptr_q;
      end
      default: begin
        bpb_wen = 1'b0;
      end
    endcase
  end

  // Sweep FSM, drop accounting and mode bit.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    mod_cfg_d  = mod_set ? mod_val : mod_cfg_q;
    n_drop_s   = 2'd0;
    case (state_q)
      ST_RUN: begin
        if (!upd_ready) begin
          n_drop_s = {1'b0, u0_valid} + {1'b0, u1_valid};
        end else begin
          n_drop_s = 2'd0;
        end
        if (clear_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_CLEAR: begin
        if (clear_req) begin
          ptr_d = '0;
        end else if (!stall) begin
          if (ptr_q == IDX_W'(ENTRIES - 1)) begin
            state_d = ST_RUN;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + IDX_W'(1);
          end
        end else begin
          ptr_d = ptr_q;
        end
      end
      default: begin
        state_d = ST_RUN;
        ptr_d   = '0;
      end
    endcase
    drop_cnt_d = sat_add8(drop_cnt_q, n_drop_s);
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      ptr_q      <= '0;
      mod_cfg_q  <= 1'b1;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      mod_cfg_q  <= mod_cfg_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign busy     = (state_q == ST_CLEAR);
  assign mod_cfg  = mod_cfg_q;
  assign drop_cnt = drop_cnt_q;

endmodule
